trace_emitter: RTL and testbench
================================

Name: trace_emitter

Overview:
- On-chip retirement trace source for the pipelined cpu; the transmit end of the REG/LOAD/STORE/HALT trace stream the phase-2 bench logs.
- Samples WB-stage register writes and MEM-stage memory accesses every cycle and stamps them with a cycle count.
- Buffers per-cycle snapshots in a FIFO and serializes them into single-event records over a valid/ready port.
- Sits beside the cpu top; its output feeds a trace sink (bench monitor or debug UART bridge).

Parameters:
DEPTH, 8, snapshot FIFO entries (power of two, >=2)
CW, 16, cycle-stamp counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wb_reg_write  in  1  WB-stage register write this cycle
wb_reg_sel  in  4  destination register
wb_reg_data  in  16  write data
mem_read  in  1  MEM-stage load this cycle
mem_write  in  1  MEM-stage store this cycle
mem_addr  in  16  memory address
mem_wdata  in  16  store data
mem_rdata  in  16  load data
halt  in  1  halt in MEM/WB
out_valid  out  1  record available
out_ready  in  1  sink accepts record
out_kind  out  2  0=REG 1=LOAD 2=STORE 3=HALT
out_tag  out  16  REG: {12'b0,reg}; LOAD/STORE: address; HALT: inst_count
out_value  out  16  REG: data; LOAD: rdata; STORE: wdata; HALT: 0
out_cycle  out  CW  cycle stamp of originating cycle
overflow  out  1  sticky: a snapshot was dropped
done  out  1  halt record delivered, stream finished

Behaviour:
- Reset (async, rst_n=0): cycle counter, inst_count, FIFO pointers, FSM -> 0/IDLE. out_valid=0, out_kind/tag/value/cycle=0, overflow=0, done=0. Reset mid-stream discards all buffered data immediately.
- Cycle counter increments every clk after reset and wraps at 2^CW. The stamp is the counter value in the sampled cycle (the first cycle after reset = 0).
- inst_count (16b, wraps) increments in each cycle where halt|wb_reg_write|mem_write is set, while not halted.
- Capture: in each cycle where any of wb_reg_write, mem_read, mem_write, halt is set and the halted latch is clear, push one snapshot containing a 4-bit flag mask, all data fields, and the stamp.
- HALT snapshots carry the inst_count that includes that cycle.
- halt sets the halted latch (cleared only by reset). All later inputs are ignored.
- FIFO full:
  - Push with a same-cycle pop is accepted.
  - Push without a pop is dropped and sets overflow. Exception: a HALT snapshot overwrites the newest entry so that it is never lost.
- Serializer FSM:
  - IDLE: if the FIFO is non-empty, load the head into the current register (pop) -> EMIT. Latency from input event to out_valid is 2 cycles with an empty FIFO.
  - EMIT: present the lowest-set flag in fixed order REG, LOAD, STORE, HALT. out_* is registered and stable while out_valid=1 && out_ready=0.
  - On handshake, clear that flag.
  - If flags remain: present the next one the following cycle.
  - If no flags remain and the FIFO is non-empty: pop the next entry the same cycle (no bubble).
  - If no flags remain and the FIFO is empty: -> IDLE.
  - If the flag just handshaken was HALT: -> DONE.
- DONE: out_valid=0 and done=1 until reset. out_ready is ignored.
- out_valid never drops without a handshake, except on reset.

Decomposition:
- Package trace_pkg:
  - kind encodings KIND_REG/LOAD/STORE/HALT
  - flag-bit indices
  - snapshot struct/width constant (4+4+16*5+CW)
  - FSM state encodings IDLE/EMIT/DONE
- Sub-module trace_fifo: synchronous FIFO, DEPTH x snapshot width, with push/pop/full/empty and overwrite-newest port. The top holds the counters, capture logic and serializer FSM.

Test Plan:
- REG write r3=0x1234 in cycle 5, out_ready=1 -> one record kind=0 tag=0x0003 value=0x1234 cycle=5, out_valid 2 cycles after the event.
- Same cycle: wb_reg_write r1=0xAAAA, mem_read addr=0x0040 rdata=0x5555, with out_ready=1 -> REG then LOAD on consecutive cycles, both stamped with the same cycle.
- Store addr=0x0010 wdata=0xBEEF with out_ready held 0 for 4 cycles -> out_* stable for 4 cycles, handshake once, no duplicate record.
- out_ready=0; 10 consecutive cycles with one reg write each (DEPTH=8) -> overflow=1. When ready is released, exactly 9 REG records arrive (8 buffered plus the one held in the current register), stamps increasing with no duplicates.
- Program: 3 reg writes, 1 store, then halt; further events asserted after halt -> records REG,REG,REG,STORE,HALT(tag=5); done=1 after the HALT handshake; post-halt events produce nothing.
- rst_n pulsed low while out_valid=1 with 4 entries buffered -> out_valid=0 immediately and counters=0. A new event after release is stamped relative to the new reset.

Source files
------------

// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trace_pkg
//  Description : Shared types and encodings for the retirement trace source:
//                record kinds, flag-bit indices, snapshot layout, FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

    // Record kind encodings presented on out_kind
    localparam logic [1:0] KIND_REG   = 2'd0;
    localparam logic [1:0] KIND_LOAD  = 2'd1;
    localparam logic [1:0] KIND_STORE = 2'd2;
    localparam logic [1:0] KIND_HALT  = 2'd3;

    // Bit positions inside the snapshot flag mask; lower index is emitted first
    localparam int FLAG_REG   = 0;
    localparam int FLAG_LOAD  = 1;
    localparam int FLAG_STORE = 2;
    localparam int FLAG_HALT  = 3;

    // Snapshot payload without the cycle stamp (stamp width is a top parameter)
    typedef struct packed {
        logic [3:0]  flags;
        logic [3:0]  regSel;
        logic [15:0] regData;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic [15:0] instCount;
    } snapFields_t;

    localparam int SNAP_BASE_W = 4 + 4 + 16 * 5;

    // Full snapshot width once the cycle stamp is appended
    function automatic int snapWidth(input int cw);
        return SNAP_BASE_W + cw;
    endfunction

    // Isolate the lowest set flag as a one-hot mask
    function automatic logic [3:0] lowestFlag(input logic [3:0] f);
        return f & (~f + 4'd1);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } emitState_t;

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : trace_fifo
//  Description : Synchronous snapshot FIFO. A push while full is accepted only
//                together with a pop; overwrite replaces the newest entry when
//                full so a terminal snapshot always survives.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             overwrite,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic [AW-1:0]    newestIdx;
    logic             doPop;
    logic             doPush;
    logic             doOver;

    assign empty     = (wrPtr == rdPtr);
    assign full      = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop     = pop && !empty;
    assign doPush    = push && (!full || doPop);
    assign doOver    = overwrite && full && !doPop;
    assign newestIdx = wrPtr[AW-1:0] - AW'(1);
    assign popData   = mem[rdPtr[AW-1:0]];

    // Storage array: normal write at the tail, or in-place overwrite of the newest
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr[AW-1:0]] <= pushData;
        end else if (doOver) begin
            mem[newestIdx] <= pushData;
        end
    end

    // Read/write pointers with a wrap bit to tell full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/trace_emitter.sv
`default_nettype none
// ============================================================================
//  Module      : trace_emitter
//  Description : Retirement trace source. Captures WB register writes and MEM
//                accesses per cycle with a cycle stamp, buffers them, and
//                serializes each snapshot into REG/LOAD/STORE/HALT records.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_emitter
    import trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_reg_write,
    input  logic [3:0]    wb_reg_sel,
    input  logic [15:0]   wb_reg_data,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [15:0]   mem_addr,
    input  logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    input  logic          halt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    out_kind,
    output logic [15:0]   out_tag,
    output logic [15:0]   out_value,
    output logic [CW-1:0] out_cycle,
    output logic          overflow,
    output logic          done
);
    localparam int SNAP_W = snapWidth(CW);

    logic [CW-1:0]     cycleCnt;
    logic [15:0]       instCount;
    logic [15:0]       instCountNext;
    logic              halted;
    logic              capture;
    logic              countInst;
    snapFields_t       capFields;
    logic [SNAP_W-1:0] headData;
    snapFields_t       headFields;
    logic [CW-1:0]     headCycle;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              fifoPop;

    emitState_t        state;
    snapFields_t       curFields;
    logic [CW-1:0]     curCycle;
    logic [3:0]        curBit;
    logic [3:0]        remaining;
    logic              handshake;

    snapFields_t       nxtFields;
    logic [CW-1:0]     nxtCycle;
    logic [3:0]        nxtBit;
    logic [1:0]        nxtKind;
    logic [15:0]       nxtTag;
    logic [15:0]       nxtValue;

    assign capture       = (wb_reg_write | mem_read | mem_write | halt) && !halted;
    assign countInst     = (halt | wb_reg_write | mem_write) && !halted;
    assign instCountNext = instCount + (countInst ? 16'd1 : 16'd0);

    // Snapshot of this cycle's retirement activity
    always_comb begin
        capFields                  = '0;
        capFields.flags[FLAG_REG]   = wb_reg_write;
        capFields.flags[FLAG_LOAD]  = mem_read;
        capFields.flags[FLAG_STORE] = mem_write;
        capFields.flags[FLAG_HALT]  = halt;
        capFields.regSel           = wb_reg_sel;
        capFields.regData          = wb_reg_data;
        capFields.addr             = mem_addr;
        capFields.wdata            = mem_wdata;
        capFields.rdata            = mem_rdata;
        capFields.instCount        = instCountNext;
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SNAP_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .overwrite (capture && halt),
        .pushData  ({capFields, cycleCnt}),
        .pop       (fifoPop),
        .popData   (headData),
        .full      (fifoFull),
        .empty     (fifoEmpty)
    );

    assign {headFields, headCycle} = headData;

    // Cycle stamp, retired-instruction count, halted latch and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycleCnt  <= '0;
            instCount <= '0;
            halted    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            cycleCnt  <= cycleCnt + CW'(1);
            instCount <= instCountNext;
            if (halt) halted <= 1'b1;
            if (capture && fifoFull && !fifoPop) overflow <= 1'b1;
        end
    end

    // Flag currently on the port, and what is left after it is accepted
    assign curBit    = lowestFlag(curFields.flags);
    assign remaining = curFields.flags & ~curBit;
    assign handshake = (state == ST_EMIT) && out_valid && out_ready;
    assign fifoPop   = ((state == ST_IDLE) ||
                        (handshake && !curBit[FLAG_HALT] && remaining == 4'd0)) && !fifoEmpty;

    // Next record to present: either a freshly popped head or the next flag of the current entry
    always_comb begin
        nxtFields       = fifoPop ? headFields : curFields;
        nxtCycle        = fifoPop ? headCycle  : curCycle;
        nxtFields.flags = fifoPop ? headFields.flags : remaining;
        nxtBit          = lowestFlag(nxtFields.flags);
        nxtKind         = KIND_REG;
        nxtTag          = {12'b0, nxtFields.regSel};
        nxtValue        = nxtFields.regData;
        if (nxtBit[FLAG_LOAD]) begin
            nxtKind  = KIND_LOAD;
            nxtTag   = nxtFields.addr;
            nxtValue = nxtFields.rdata;
        end else if (nxtBit[FLAG_STORE]) begin
            nxtKind  = KIND_STORE;
            nxtTag   = nxtFields.addr;
            nxtValue = nxtFields.wdata;
        end else if (nxtBit[FLAG_HALT]) begin
            nxtKind  = KIND_HALT;
            nxtTag   = nxtFields.instCount;
            nxtValue = 16'd0;
        end
    end

    // Serializer FSM with registered record outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            curFields <= '0;
            curCycle  <= '0;
            out_valid <= 1'b0;
            out_kind  <= '0;
            out_tag   <= '0;
            out_value <= '0;
            out_cycle <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_EMIT: begin
                    if (fifoPop || (handshake && !curBit[FLAG_HALT] && remaining != 4'd0)) begin
                        state     <= ST_EMIT;
                        out_valid <= 1'b1;
                        curFields <= nxtFields;
                        curCycle  <= nxtCycle;
                        out_kind  <= nxtKind;
                        out_tag   <= nxtTag;
                        out_value <= nxtValue;
                        out_cycle <= nxtCycle;
                    end else if (handshake && curBit[FLAG_HALT]) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end else if (handshake) begin
                        state           <= ST_IDLE;
                        out_valid       <= 1'b0;
                        curFields.flags <= 4'd0;
                    end
                end
                ST_DONE: begin
                    out_valid <= 1'b0;
                    done      <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trace_emitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trace_emitter
//  Description : Self-checking bench for trace_emitter. Expected records are
//                queued as stimulus is driven and matched on each handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_emitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_reg_write = 1'b0;
    logic [3:0]  wb_reg_sel = '0;
    logic [15:0] wb_reg_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic [15:0] mem_rdata = '0;
    logic        halt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_kind;
    logic [15:0] out_tag;
    logic [15:0] out_value;
    logic [15:0] out_cycle;
    logic        overflow;
    logic        done;

    int checks = 0;
    int failures = 0;
    int tbCycle = 0;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] tag;
        logic [15:0] value;
        logic [15:0] cyc;
    } rec_t;

    rec_t expQ[$];
    int   hsQ[$];

    trace_emitter #(.DEPTH(8), .CW(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_reg_write (wb_reg_write),
        .wb_reg_sel   (wb_reg_sel),
        .wb_reg_data  (wb_reg_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .halt         (halt),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_kind     (out_kind),
        .out_tag      (out_tag),
        .out_value    (out_value),
        .out_cycle    (out_cycle),
        .overflow     (overflow),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Reference cycle count: value the DUT stamps during the coming posedge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tbCycle <= 0;
        else        tbCycle <= tbCycle + 1;
    end

    // Scoreboard: every accepted record must match the oldest expected one
    always begin
        rec_t e;
        @(negedge clk);
        #2;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("FAIL unexpected_record kind=%0d tag=%h value=%h cycle=%0d", out_kind, out_tag, out_value, out_cycle);
            end else begin
                e = expQ.pop_front();
                if (out_kind !== e.kind || out_tag !== e.tag || out_value !== e.value || out_cycle !== e.cyc) begin
                    failures++;
                    $display("FAIL record got kind=%0d tag=%h value=%h cycle=%0d expected kind=%0d tag=%h value=%h cycle=%0d",
                             out_kind, out_tag, out_value, out_cycle, e.kind, e.tag, e.value, e.cyc);
                end
            end
            hsQ.push_back(tbCycle);
        end
    end

    task automatic clearIn();
        wb_reg_write = 1'b0; wb_reg_sel = '0; wb_reg_data = '0;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0;
        mem_wdata = '0; mem_rdata = '0; halt = 1'b0;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n = 1'b0;
        clearIn();
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        expQ.delete();
        hsQ.delete();
        rst_n = 1'b1;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 300 && expQ.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL %s_drain pending=%0d required=0", name, expQ.size());
        end
    endtask

    task automatic test_reset();
        resetDut();
        #1;
        checks++;
        if ({out_valid, overflow, done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags valid/ovf/done=%b required=000", {out_valid, overflow, done});
        end
        checks++;
        if ({out_kind, out_tag, out_value, out_cycle} !== 50'd0) begin
            failures++;
            $display("FAIL reset_data kind=%0d tag=%h value=%h cycle=%0d required=0", out_kind, out_tag, out_value, out_cycle);
        end
    endtask

    task automatic test_reg();
        resetDut();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && tbCycle != 5; i++) @(negedge clk);
        wb_reg_write = 1'b1; wb_reg_sel = 4'd3; wb_reg_data = 16'h1234;
        expQ.push_back({2'd0, 16'h0003, 16'h1234, 16'(tbCycle)});
        @(negedge clk);
        clearIn();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reg_latency1 valid=%b required=0", out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL reg_latency2 valid=%b required=1", out_valid);
        end
        waitDrain("reg");
    endtask

    task automatic test_same_cycle();
        resetDut();
        out_ready = 1'b1;
        @(negedge clk);
        wb_reg_write = 1'b1; wb_reg_sel = 4'd1; wb_reg_data = 16'hAAAA;
        mem_read = 1'b1; mem_addr = 16'h0040; mem_rdata = 16'h5555;
        expQ.push_back({2'd0, 16'h0001, 16'hAAAA, 16'(tbCycle)});
        expQ.push_back({2'd1, 16'h0040, 16'h5555, 16'(tbCycle)});
        @(negedge clk);
        clearIn();
        waitDrain("same_cycle");
        checks++;
        if (hsQ.size() != 2 || hsQ[1] - hsQ[0] != 1) begin
            failures++;
            $display("FAIL same_cycle_spacing count=%0d gap=%0d required count=2 gap=1",
                     hsQ.size(), (hsQ.size() == 2) ? hsQ[1] - hsQ[0] : -1);
        end
    endtask

    task automatic test_stall();
        logic [50:0] held;
        resetDut();
        @(negedge clk);
        mem_write = 1'b1; mem_addr = 16'h0010; mem_wdata = 16'hBEEF;
        expQ.push_back({2'd2, 16'h0010, 16'hBEEF, 16'(tbCycle)});
        @(negedge clk);
        clearIn();
        for (int i = 0; i < 10 && out_valid !== 1'b1; i++) begin
            @(negedge clk);
            #1;
        end
        held = {out_valid, out_kind, out_tag, out_value, out_cycle};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({out_valid, out_kind, out_tag, out_value, out_cycle} !== held || held[50] !== 1'b1) begin
                failures++;
                $display("FAIL stall_stable cyc=%0d got=%h required=%h (valid=1)", i,
                         {out_valid, out_kind, out_tag, out_value, out_cycle}, held);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_release valid=%b required=0", out_valid);
        end
        out_ready = 1'b1;
        waitDrain("stall");
        checks++;
        if (hsQ.size() != 1) begin
            failures++;
            $display("FAIL stall_count records=%0d required=1", hsQ.size());
        end
    endtask

    task automatic test_overflow();
        resetDut();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wb_reg_write = 1'b1; wb_reg_sel = 4'(i); wb_reg_data = 16'h0100 + 16'(i);
            if (i < 9) expQ.push_back({2'd0, 16'(i), 16'h0100 + 16'(i), 16'(tbCycle)});
        end
        @(negedge clk);
        clearIn();
        #1;
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_flag got=%b required=1", overflow);
        end
        out_ready = 1'b1;
        waitDrain("overflow");
        checks++;
        if (hsQ.size() != 9) begin
            failures++;
            $display("FAIL overflow_count records=%0d required=9", hsQ.size());
        end
    endtask

    task automatic test_halt();
        resetDut();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clearIn();
            wb_reg_write = 1'b1; wb_reg_sel = 4'(i + 2); wb_reg_data = 16'hC000 + 16'(i);
            expQ.push_back({2'd0, 16'(i + 2), 16'hC000 + 16'(i), 16'(tbCycle)});
        end
        @(negedge clk);
        clearIn();
        mem_write = 1'b1; mem_addr = 16'h0200; mem_wdata = 16'h5A5A;
        expQ.push_back({2'd2, 16'h0200, 16'h5A5A, 16'(tbCycle)});
        @(negedge clk);
        clearIn();
        halt = 1'b1;
        expQ.push_back({2'd3, 16'd5, 16'h0000, 16'(tbCycle)});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wb_reg_write = 1'b1; mem_write = 1'b1; mem_read = 1'b1; halt = 1'b1;
        end
        @(negedge clk);
        clearIn();
        waitDrain("halt");
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_done done=%b valid=%b required done=1 valid=0", done, out_valid);
        end
        checks++;
        if (hsQ.size() != 5) begin
            failures++;
            $display("FAIL halt_count records=%0d required=5", hsQ.size());
        end
    endtask

    task automatic test_halt_full();
        resetDut();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wb_reg_write = 1'b1; wb_reg_sel = 4'(i); wb_reg_data = 16'h0300 + 16'(i);
            if (i < 8) expQ.push_back({2'd0, 16'(i), 16'h0300 + 16'(i), 16'(tbCycle)});
        end
        @(negedge clk);
        clearIn();
        halt = 1'b1;
        expQ.push_back({2'd3, 16'd11, 16'h0000, 16'(tbCycle)});
        @(negedge clk);
        clearIn();
        out_ready = 1'b1;
        waitDrain("halt_full");
        #1;
        checks++;
        if (done !== 1'b1 || hsQ.size() != 9) begin
            failures++;
            $display("FAIL halt_full_done done=%b records=%0d required done=1 records=9", done, hsQ.size());
        end
    endtask

    task automatic test_reset_mid();
        resetDut();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wb_reg_write = 1'b1; wb_reg_sel = 4'(i); wb_reg_data = 16'h0400 + 16'(i);
        end
        @(negedge clk);
        clearIn();
        for (int i = 0; i < 10 && out_valid !== 1'b1; i++) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_cycle !== 16'd0 || out_kind !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_async valid=%b cycle=%0d kind=%0d required 0", out_valid, out_cycle, out_kind);
        end
        expQ.delete();
        hsQ.delete();
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20 && tbCycle != 3; i++) @(negedge clk);
        wb_reg_write = 1'b1; wb_reg_sel = 4'd7; wb_reg_data = 16'h7777;
        expQ.push_back({2'd0, 16'h0007, 16'h7777, 16'(tbCycle)});
        @(negedge clk);
        clearIn();
        waitDrain("reset_mid");
        checks++;
        if (hsQ.size() != 1) begin
            failures++;
            $display("FAIL reset_mid_count records=%0d required=1", hsQ.size());
        end
    endtask

    initial begin
        test_reset();
        test_reg();
        test_same_cycle();
        test_stall();
        test_overflow();
        test_halt();
        test_halt_full();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
